alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one 32-bit ALU between two requesters, such as the execute path and a debug/test port. Each requester presents operands and a 3-bit ALUOp through a valid/ready handshake. The block grants one requester, drives the shared ALU from registered operands, captures the ALU result, and returns it to the winner through a valid/ready response handshake. The ALU itself sits outside this block and connects through the `alu_*` ports.

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter that shares one external
// combinational ALU. It accepts one request, drives the ALU from registered
// operands, captures the result, and returns it through a valid/ready
// response handshake to the requester that won.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_A_0,
  input  logic [WIDTH-1:0] req_B_0,
  input  logic [OPW-1:0]   req_op_0,
  output logic             resp_valid_0,
  input  logic             resp_ready_0,
  // requester 1
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_A_1,
  input  logic [WIDTH-1:0] req_B_1,
  input  logic [OPW-1:0]   req_op_1,
  output logic             resp_valid_1,
  input  logic             resp_ready_1,
  // shared result
  output logic [WIDTH-1:0] resp_C,
  // external ALU
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_C
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             grant_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [OPW-1:0]   op_q;

  logic             win;
  logic             accept;
  logic             resp_ready_g;
  logic             resp_done;

  // Round-robin choice: a lone requester always wins; on contention the
  // port that was not served last goes next.
  always_comb begin
    win = 1'b0;
    if (req_valid_0 && !req_valid_1)
      win = 1'b0;
    else if (req_valid_1 && !req_valid_0)
      win = 1'b1;
    else if (req_valid_0 && req_valid_1)
      win = ~last_grant_q;
  end

  // Only the granted port's response ready is honoured.
  always_comb begin
    resp_ready_g = grant_q ? resp_ready_1 : resp_ready_0;
  end

  // Next-state and handshake decode; reset suppresses acceptance in the same cycle.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset && (req_valid_0 || req_valid_1)) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_g) begin
          resp_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping, operand capture and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      c_q          <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= win;
        a_q     <= win ? req_A_1  : req_A_0;
        b_q     <= win ? req_B_1  : req_B_0;
        op_q    <= win ? req_op_1 : req_op_0;
      end
      if (state_q == EXEC)
        c_q <= alu_C;
      if (resp_done)
        last_grant_q <= grant_q;
    end
  end

  // Request ready is combinational; response valid is decoded from registered state only.
  always_comb begin
    req_ready_0  = accept && !win;
    req_ready_1  = accept && win;
    resp_valid_0 = (state_q == RESP) && !grant_q;
    resp_valid_1 = (state_q == RESP) && grant_q;
    resp_C       = c_q;
    alu_A        = a_q;
    alu_B        = b_q;
    alu_op       = op_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboarded bench for alu_arbiter: expected responses are queued at
// acceptance time and a monitor pops them on each response handshake.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_0, req_ready_0, resp_valid_0, resp_ready_0;
  logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1;
  logic [31:0] req_A_0, req_B_0, req_A_1, req_B_1;
  logic [2:0]  req_op_0, req_op_1;
  logic [31:0] resp_C, alu_A, alu_B, alu_C;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [31:0] c;
  } exp_t;
  exp_t sb[$];

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_A_0(req_A_0), .req_B_0(req_B_0), .req_op_0(req_op_0),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_A_1(req_A_1), .req_B_1(req_B_1), .req_op_1(req_op_1),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
    .resp_C(resp_C), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_C(alu_C)
  );

  always #5 clk = ~clk;

  // External ALU the arbiter drives.
  always_comb begin
    case (alu_op)
      3'b000:  alu_C = alu_A + alu_B;
      3'b001:  alu_C = alu_A - alu_B;
      3'b010:  alu_C = alu_A & alu_B;
      3'b011:  alu_C = alu_A | alu_B;
      3'b100:  alu_C = alu_A >> alu_B;
      3'b101:  alu_C = $unsigned($signed(alu_A) >>> alu_B);
      default: alu_C = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [31:0] c);
    exp_t e;
    e.port = p;
    e.c    = c;
    sb.push_back(e);
  endtask

  // Monitor: every response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? (resp_valid_0 && resp_ready_0) : (resp_valid_1 && resp_ready_1)) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: port %0d data 0x%08h, none expected", p, resp_C);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.port != p || resp_C !== e.c) begin
              errors++;
              $display("FAIL resp: got port %0d data 0x%08h expected port %0d data 0x%08h",
                       p, resp_C, e.port, e.c);
            end
          end
        end
      end
    end
  end

  // Starts and ends just after a rising edge.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp);
    bit got = 0;
    if (p == 0) begin
      req_valid_0 = 1; req_A_0 = a; req_B_0 = b; req_op_0 = op;
    end else begin
      req_valid_1 = 1; req_A_1 = a; req_B_1 = b; req_op_1 = op;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? req_ready_0 : req_ready_1) begin
        push(p, exp);
        got = 1;
      end
      @(posedge clk); #1;
    end
    if (p == 0) req_valid_0 = 0; else req_valid_1 = 0;
    if (!got) chk("issue_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    resp_ready_0 = 1;
    resp_ready_1 = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid_0 && !resp_valid_1) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bit got;
    int n, expg;
    reset = 1;
    req_valid_0 = 1; req_A_0 = 5; req_B_0 = 3; req_op_0 = 3'b001;
    req_valid_1 = 0; req_A_1 = 0; req_B_1 = 0; req_op_1 = 0;
    resp_ready_0 = 1; resp_ready_1 = 1;

    // Reset state, with a request pending that must not be acknowledged.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready_0", {31'b0, req_ready_0}, 0);
    chk("rst_resp_valid", {30'b0, resp_valid_1, resp_valid_0}, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_alu_op", {29'b0, alu_op}, 0);
    chk("rst_resp_C", resp_C, 0);
    @(posedge clk); #1;
    reset = 0;

    // Single op with cycle-exact timing.
    @(negedge clk);
    chk("single_req_ready_0", {31'b0, req_ready_0}, 1);
    chk("single_req_ready_1", {31'b0, req_ready_1}, 0);
    push(0, 32'd2);
    @(posedge clk); #1;
    req_valid_0 = 0;
    @(negedge clk);
    chk("single_alu_A", alu_A, 5);
    chk("single_alu_B", alu_B, 3);
    chk("single_alu_op", {29'b0, alu_op}, 1);
    chk("single_no_resp_exec", {31'b0, resp_valid_0}, 0);
    @(negedge clk);
    chk("single_resp_valid_0", {31'b0, resp_valid_0}, 1);
    chk("single_resp_C", resp_C, 2);
    chk("single_resp_valid_1", {31'b0, resp_valid_1}, 0);
    @(posedge clk); #1;
    drain();

    // Shifts and boundary arithmetic on port 1.
    issue(1, 32'h8000_0000, 32'd4, 3'b101, 32'hF800_0000);
    issue(1, 32'h8000_0000, 32'd4, 3'b100, 32'h0800_0000);
    issue(1, 32'h8000_0000, 32'd4, 3'b111, 32'h0);
    issue(1, 32'h8000_0000, 32'd40, 3'b100, 32'h0);
    issue(0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'h0);
    issue(0, 32'h0, 32'd1, 3'b001, 32'hFFFF_FFFF);
    issue(0, 32'hF0F0_0000, 32'h0000_0F0F, 3'b011, 32'hF0F0_0F0F);
    drain();

    // Contention from reset: grants alternate starting with port 0.
    reset = 1;
    req_valid_0 = 1; req_A_0 = 1; req_B_0 = 1; req_op_0 = 3'b000;
    req_valid_1 = 1; req_A_1 = 6; req_B_1 = 3; req_op_1 = 3'b010;
    @(negedge clk);
    chk("rst_ready_forced", {30'b0, req_ready_1, req_ready_0}, 0);
    @(posedge clk); #1;
    reset = 0;
    n = 0; expg = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (req_ready_0 || req_ready_1) begin
        chk("grant_order", {31'b0, req_ready_1}, expg);
        push(req_ready_1 ? 1 : 0, 32'd2);
        expg ^= 1;
        n++;
      end
      @(posedge clk); #1;
    end
    req_valid_0 = 0; req_valid_1 = 0;
    if (n != 6) chk("contention_timeout", n, 6);
    drain();

    // Backpressure on port 0 while port 1 waits.
    resp_ready_0 = 0;
    issue(0, 32'd10, 32'd20, 3'b000, 32'd30);
    req_valid_1 = 1; req_A_1 = 7; req_B_1 = 2; req_op_1 = 3'b100;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid_0) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk("bp_resp_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid_0", {31'b0, resp_valid_0}, 1);
      chk("bp_resp_C", resp_C, 30);
      chk("bp_req_ready_1", {31'b0, req_ready_1}, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready_0 = 1;
    @(negedge clk);
    chk("bp_req_ready_1_hs", {31'b0, req_ready_1}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_port1_granted", {31'b0, req_ready_1}, 1);
    if (req_ready_1) push(1, 32'd1);
    @(posedge clk); #1;
    req_valid_1 = 0;
    drain();

    // Reset during EXEC; port 0 served last, yet reset restores port-0 priority.
    issue(0, 32'd1, 32'd2, 3'b000, 32'd3);
    drain();
    req_valid_1 = 1; req_A_1 = 32'hDEAD; req_B_1 = 32'hBEEF; req_op_1 = 3'b011;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = req_ready_1;
      @(posedge clk); #1;
    end
    if (!got) chk("mid_accept_timeout", 0, 1);
    req_valid_1 = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_resp_valid", {30'b0, resp_valid_1, resp_valid_0}, 0);
    chk("mid_alu_A", alu_A, 0);
    chk("mid_alu_B", alu_B, 0);
    chk("mid_resp_C", resp_C, 0);
    @(posedge clk); #1;
    req_valid_0 = 1; req_A_0 = 2; req_B_0 = 2; req_op_0 = 3'b000;
    req_valid_1 = 1; req_A_1 = 9; req_B_1 = 3; req_op_1 = 3'b001;
    @(negedge clk);
    chk("post_rst_first_0", {31'b0, req_ready_0}, 1);
    chk("post_rst_first_1", {31'b0, req_ready_1}, 0);
    if (req_ready_0) push(0, 32'd4);
    @(posedge clk); #1;
    req_valid_0 = 0;
    issue(1, 32'd9, 32'd3, 3'b001, 32'd6);
    drain();

    // Wrong-port ready is ignored while port 1 holds a response.
    resp_ready_0 = 0; resp_ready_1 = 0;
    issue(1, 32'd5, 32'd5, 3'b010, 32'd5);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid_1) got = 1;
      @(posedge clk); #1;
    end
    if (!got) chk("wp_resp_timeout", 0, 1);
    resp_ready_0 = 1;
    @(negedge clk);
    chk("wp_hold_1", {31'b0, resp_valid_1}, 1);
    @(posedge clk); #1;
    resp_ready_0 = 0;
    @(negedge clk);
    chk("wp_hold_2", {31'b0, resp_valid_1}, 1);
    chk("wp_resp_C", resp_C, 5);
    @(posedge clk); #1;
    resp_ready_1 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wp_done", {31'b0, resp_valid_1}, 0);
    @(posedge clk); #1;
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
